// File: rtl/char_move_controller.sv
// -----------------------------------------------------------------------------
// char_move_controller
//
// Converts USB HID keycodes into tile-locked character motion for the frame
// drawer. Every step moves exactly TILE pixels. Time advances one tick per
// video frame. The tick comes from the end of the active-low vsync pulse.
//
// Ports
//   Clk            in   1   system clock
//   Reset_n        in   1   asynchronous active-low reset
//   VGA_VS         in   1   vsync, asynchronous to Clk, active-low
//   keycode        in   8   USB HID keycode, 0 = no key
//   state_num      in   4   game state; motion is enabled only when == 3
//   direction      out  2   0 down, 1 up, 2 left, 3 right
//   charMoveFrame  out  2   walk-cycle frame 0..2
//   charIsMoving   out  1   high while a step is in progress
//   charIsRunning  out  1   high while the current step is a run
//   char_x         out 10   map x of the character box (top-left), pixels
//   char_y         out 10   map y of the character box (top-left), pixels
//   move_done      out  1   one-Clk pulse when a step completes
// -----------------------------------------------------------------------------
module char_move_controller #(
    parameter int unsigned TILE        = 16,
    parameter int unsigned TURN_FRAMES = 4,
    parameter int unsigned ANIM_DIV    = 4,
    parameter int unsigned START_X     = 224,
    parameter int unsigned START_Y     = 362,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 448,
    parameter int unsigned Y_MIN       = 0,
    parameter int unsigned Y_MAX       = 448
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       VGA_VS,
    input  logic [7:0] keycode,
    input  logic [3:0] state_num,
    output logic [1:0] direction,
    output logic [1:0] charMoveFrame,
    output logic       charIsMoving,
    output logic       charIsRunning,
    output logic [9:0] char_x,
    output logic [9:0] char_y,
    output logic       move_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [9:0]  TILE10    = 10'(TILE);
    localparam logic [9:0]  START_X10 = 10'(START_X);
    localparam logic [9:0]  START_Y10 = 10'(START_Y);
    localparam logic [10:0] TILE11    = 11'(TILE);
    localparam logic [10:0] X_MIN11   = 11'(X_MIN);
    localparam logic [10:0] X_MAX11   = 11'(X_MAX);
    localparam logic [10:0] Y_MIN11   = 11'(Y_MIN);
    localparam logic [10:0] Y_MAX11   = 11'(Y_MAX);
    localparam logic [7:0]  TURN_LAST = 8'(TURN_FRAMES - 1);
    localparam logic [7:0]  ANIM_TOP  = 8'(ANIM_DIV);

    // vsync synchronizer and edge detect
    logic vs_meta_q, vs_meta_d;
    logic vs_sync_q, vs_sync_d;
    logic vs_prev_q, vs_prev_d;
    logic tick;

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] frame_q, frame_d;
    logic       moving_q, moving_d;
    logic       running_q, running_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       done_q, done_d;
    logic [7:0] turn_q, turn_d;
    logic [7:0] anim_q, anim_d;
    logic [9:0] rem_q, rem_d;

    logic       key_valid;
    logic       key_run;
    logic [1:0] key_dir;
    logic       blocked;
    logic [9:0] step_px;

    always_comb begin
        vs_meta_d = VGA_VS;
        vs_sync_d = vs_meta_q;
        vs_prev_d = vs_sync_q;
    end

    // Rising edge of the synchronized vsync marks the end of the pulse.
    assign tick = vs_sync_q & ~vs_prev_q;

    always_comb begin
        key_valid = 1'b1;
        key_run   = 1'b0;
        key_dir   = 2'd0;
        case (keycode)
            8'h16: key_dir = 2'd0;
            8'h1A: key_dir = 2'd1;
            8'h04: key_dir = 2'd2;
            8'h07: key_dir = 2'd3;
            8'h51: begin key_dir = 2'd0; key_run = 1'b1; end
            8'h52: begin key_dir = 2'd1; key_run = 1'b1; end
            8'h50: begin key_dir = 2'd2; key_run = 1'b1; end
            8'h4F: begin key_dir = 2'd3; key_run = 1'b1; end
            default: key_valid = 1'b0;
        endcase
    end

    // Bounds are checked in 11 bits so a target below zero cannot wrap.
    always_comb begin
        blocked = 1'b0;
        case (key_dir)
            2'd0: blocked = ({1'b0, y_q} + TILE11) > Y_MAX11;
            2'd1: blocked = {1'b0, y_q} < (Y_MIN11 + TILE11);
            2'd2: blocked = {1'b0, x_q} < (X_MIN11 + TILE11);
            default: blocked = ({1'b0, x_q} + TILE11) > X_MAX11;
        endcase
    end

    assign step_px = running_q ? 10'd2 : 10'd1;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        frame_d   = frame_q;
        moving_d  = moving_q;
        running_d = running_q;
        x_d       = x_q;
        y_d       = y_q;
        done_d    = 1'b0;
        turn_d    = turn_q;
        anim_d    = anim_q;
        rem_d     = rem_q;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (key_valid) begin
                        if (key_dir != dir_q) begin
                            dir_d   = key_dir;
                            state_d = TURN;
                            turn_d  = '0;
                        end else if (!blocked) begin
                            state_d   = STEP;
                            rem_d     = TILE10;
                            moving_d  = 1'b1;
                            running_d = key_run;
                            frame_d   = 2'd1;
                            anim_d    = '0;
                        end
                    end
                end
                TURN: begin
                    turn_d = turn_q + 8'd1;
                    if (turn_q == TURN_LAST) begin
                        state_d = IDLE;
                    end
                end
                STEP: begin
                    case (dir_q)
                        2'd0: y_d = y_q + step_px;
                        2'd1: y_d = y_q - step_px;
                        2'd2: x_d = x_q - step_px;
                        default: x_d = x_q + step_px;
                    endcase
                    rem_d = rem_q - step_px;
                    if ((anim_q + 8'd1) == ANIM_TOP) begin
                        anim_d  = '0;
                        frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
                    end else begin
                        anim_d = anim_q + 8'd1;
                    end
                    if (rem_q == step_px) begin
                        state_d   = IDLE;
                        moving_d  = 1'b0;
                        running_d = 1'b0;
                        frame_d   = 2'd0;
                        anim_d    = '0;
                        done_d    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Leaving the play state abandons any step where it stands. It acts on
        // every Clk, not only on ticks.
        if (state_num != 4'd3) begin
            state_d   = IDLE;
            moving_d  = 1'b0;
            running_d = 1'b0;
            frame_d   = 2'd0;
            done_d    = 1'b0;
            turn_d    = '0;
            anim_d    = '0;
            rem_d     = '0;
            if (state_num == 4'd0) begin
                x_d   = START_X10;
                y_d   = START_Y10;
                dir_d = 2'd0;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // vsync idles high, so preload high to avoid a false tick after reset
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            vs_prev_q <= 1'b1;
            state_q   <= IDLE;
            dir_q     <= 2'd0;
            frame_q   <= 2'd0;
            moving_q  <= 1'b0;
            running_q <= 1'b0;
            x_q       <= START_X10;
            y_q       <= START_Y10;
            done_q    <= 1'b0;
            turn_q    <= '0;
            anim_q    <= '0;
            rem_q     <= '0;
        end else begin
            vs_meta_q <= vs_meta_d;
            vs_sync_q <= vs_sync_d;
            vs_prev_q <= vs_prev_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            frame_q   <= frame_d;
            moving_q  <= moving_d;
            running_q <= running_d;
            x_q       <= x_d;
            y_q       <= y_d;
            done_q    <= done_d;
            turn_q    <= turn_d;
            anim_q    <= anim_d;
            rem_q     <= rem_d;
        end
    end

    assign direction     = dir_q;
    assign charMoveFrame = frame_q;
    assign charIsMoving  = moving_q;
    assign charIsRunning = running_q;
    assign char_x        = x_q;
    assign char_y        = y_q;
    assign move_done     = done_q;

endmodule

// File: tb/tb_char_move_controller.sv
// -----------------------------------------------------------------------------
// tb_char_move_controller
//
// Directed, table-driven bench. Each table record holds the inputs applied
// for one video frame and the outputs expected after that frame's tick.
// Hand-written sequences cover the tick latency, leaving the play state, and
// an asynchronous reset in the middle of a step.
// -----------------------------------------------------------------------------
module tb_char_move_controller;

    logic       Clk;
    logic       Reset_n;
    logic       VGA_VS;
    logic [7:0] keycode;
    logic [3:0] state_num;
    logic [1:0] direction;
    logic [1:0] charMoveFrame;
    logic       charIsMoving;
    logic       charIsRunning;
    logic [9:0] char_x;
    logic [9:0] char_y;
    logic       move_done;

    char_move_controller dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .VGA_VS        (VGA_VS),
        .keycode       (keycode),
        .state_num     (state_num),
        .direction     (direction),
        .charMoveFrame (charMoveFrame),
        .charIsMoving  (charIsMoving),
        .charIsRunning (charIsRunning),
        .char_x        (char_x),
        .char_y        (char_y),
        .move_done     (move_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0]  key;
        logic [1:0]  dir;
        logic [1:0]  frm;
        logic        mov;
        logic        run;
        logic [9:0]  x;
        logic [9:0]  y;
        int unsigned done;
    } vec_t;

    vec_t        vq[$];
    int unsigned vec_cnt  = 0;
    int unsigned err_cnt  = 0;
    int unsigned done_cnt = 0;
    int unsigned ex, ey, edone;

    // move_done is one Clk wide, so sampling each falling edge counts it once
    always @(negedge Clk) if (move_done === 1'b1) done_cnt++;

    task automatic push(input logic [7:0] key, input logic [1:0] d, input logic [1:0] f,
                        input logic m, input logic r);
        vec_t v;
        v.key = key; v.dir = d; v.frm = f; v.mov = m; v.run = r;
        v.x = 10'(ex); v.y = 10'(ey); v.done = edone;
        vq.push_back(v);
    endtask

    // Change of heading: one tick to enter TURN plus four ticks spent turning.
    task automatic add_turn(input logic [7:0] key, input logic [1:0] d);
        for (int i = 0; i < 5; i++) push(key, d, 2'd0, 1'b0, 1'b0);
    endtask

    // One complete step: the start tick, then TILE/speed moving ticks.
    task automatic add_step(input logic [7:0] kstart, input logic [7:0] khold,
                            input logic [1:0] d, input logic run);
        int unsigned spd, n;
        spd = run ? 2 : 1;
        n   = 16 / spd;
        push(kstart, d, 2'd1, 1'b1, run);
        for (int i = 1; i <= int'(n); i++) begin
            case (d)
                2'd0: ey = ey + spd;
                2'd1: ey = ey - spd;
                2'd2: ex = ex - spd;
                default: ex = ex + spd;
            endcase
            if (i == int'(n)) begin
                edone++;
                push(khold, d, 2'd0, 1'b0, 1'b0);
            end else begin
                push(khold, d, 2'(((i / 4) + 1) % 3), 1'b1, run);
            end
        end
    endtask

    task automatic frame();
        @(negedge Clk) VGA_VS = 1'b0;
        repeat (3) @(negedge Clk);
        VGA_VS = 1'b1;
        repeat (5) @(negedge Clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        VGA_VS    = 1'b1;
        keycode   = 8'h00;
        state_num = 4'd3;

        repeat (3) @(negedge Clk);
        check("reset_dir",   32'(direction),     32'd0);
        check("reset_frame", 32'(charMoveFrame), 32'd0);
        check("reset_mov",   32'(charIsMoving),  32'd0);
        check("reset_run",   32'(charIsRunning), 32'd0);
        check("reset_x",     32'(char_x),        32'd224);
        check("reset_y",     32'(char_y),        32'd362);
        check("reset_done",  32'(move_done),     32'd0);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);

        // Build the table of per-frame vectors.
        ex = 224; ey = 362; edone = 0;
        add_step(8'h16, 8'h00, 2'd0, 1'b0);            // walk down, key released
        add_turn(8'h07, 2'd3);                         // turn right
        add_step(8'h07, 8'h07, 2'd3, 1'b0);            // walk right, key held
        add_turn(8'h50, 2'd2);                         // turn left
        add_step(8'h50, 8'h00, 2'd2, 1'b1);            // run left
        add_turn(8'h16, 2'd0);                         // turn down
        for (int s = 0; s < 4; s++) add_step(8'h16, 8'h16, 2'd0, 1'b0);
        for (int b = 0; b < 3; b++) push(8'h16, 2'd0, 2'd0, 1'b0, 1'b0); // y=442 blocked

        foreach (vq[i]) begin
            keycode = vq[i].key;
            frame();
            vec_cnt++;
            if ({direction, charMoveFrame, charIsMoving, charIsRunning, char_x, char_y} !==
                {vq[i].dir, vq[i].frm, vq[i].mov, vq[i].run, vq[i].x, vq[i].y} ||
                done_cnt != vq[i].done) begin
                err_cnt++;
                $display("FAIL vec%0d: got dir=%0d frm=%0d mov=%0d run=%0d x=%0d y=%0d done=%0d expected dir=%0d frm=%0d mov=%0d run=%0d x=%0d y=%0d done=%0d",
                         i, direction, charMoveFrame, charIsMoving, charIsRunning, char_x, char_y, done_cnt,
                         vq[i].dir, vq[i].frm, vq[i].mov, vq[i].run, vq[i].x, vq[i].y, vq[i].done);
            end
        end
        keycode = 8'h00;

        // state_num 0 reloads the start position while idle.
        @(negedge Clk) state_num = 4'd0;
        @(negedge Clk);
        check("reload_x", 32'(char_x), 32'd224);
        check("reload_y", 32'(char_y), 32'd362);
        state_num = 4'd3;

        // Tick latency: the first effect lands on the third Clk after the vsync rise.
        keycode = 8'h16;
        @(negedge Clk) VGA_VS = 1'b0;
        repeat (3) @(negedge Clk);
        VGA_VS = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("latency_2clk", 32'(charIsMoving), 32'd0);
        @(negedge Clk);
        check("latency_3clk", 32'(charIsMoving), 32'd1);
        keycode = 8'h00;
        repeat (3) frame();
        check("midstep_y", 32'(char_y), 32'd365);

        // Mid-step state_num 3 -> 0: abandon and reload on the next Clk.
        @(negedge Clk) state_num = 4'd0;
        @(negedge Clk);
        check("abort0_mov", 32'(charIsMoving),  32'd0);
        check("abort0_x",   32'(char_x),        32'd224);
        check("abort0_y",   32'(char_y),        32'd362);
        check("abort0_dir", 32'(direction),     32'd0);
        state_num = 4'd3;

        // Mid-step state_num 3 -> 5: abandon in place, no further motion.
        keycode = 8'h16;
        frame();
        keycode = 8'h00;
        repeat (3) frame();
        @(negedge Clk) state_num = 4'd5;
        @(negedge Clk);
        check("abort5_mov",   32'(charIsMoving),  32'd0);
        check("abort5_frame", 32'(charMoveFrame), 32'd0);
        check("abort5_y",     32'(char_y),        32'd365);
        keycode = 8'h16;
        frame();
        check("abort5_hold_y", 32'(char_y), 32'd365);
        keycode = 8'h00;
        state_num = 4'd3;

        // Asynchronous reset mid-step, observed before any Clk edge.
        @(negedge Clk) state_num = 4'd0;
        @(negedge Clk) state_num = 4'd3;
        keycode = 8'h51;
        frame();
        keycode = 8'h00;
        repeat (2) frame();
        check("pre_rst_y",   32'(char_y),        32'd366);
        check("pre_rst_run", 32'(charIsRunning), 32'd1);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("arst_mov",   32'(charIsMoving),  32'd0);
        check("arst_run",   32'(charIsRunning), 32'd0);
        check("arst_frame", 32'(charMoveFrame), 32'd0);
        check("arst_y",     32'(char_y),        32'd362);
        check("arst_x",     32'(char_x),        32'd224);
        check("arst_dir",   32'(direction),     32'd0);
        @(negedge Clk) Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
